// File: rtl/fp4_twiddle_seq.sv
// Twiddle/address sequencer for an iterative radix-2 DIT FFT with FP4 (E2M1) twiddles.
// Walks every (stage, butterfly) pair and presents one registered bundle per valid/ready handshake.
module fp4_twiddle_seq #(
  parameter int LOG2N = 3
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic                                 out_ready,
  output logic                                 out_valid,
  output logic [3:0]                           tw_re,
  output logic [3:0]                           tw_im,
  output logic [LOG2N-1:0]                     addr_top,
  output logic [LOG2N-1:0]                     addr_bot,
  output logic [((LOG2N>1)?$clog2(LOG2N):1)-1:0] stage,
  output logic                                 last,
  output logic                                 busy,
  output logic                                 done,
  output logic [1:0]                           state_dbg
);

  localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;
  localparam int BW = LOG2N - 1;
  localparam logic [BW-1:0] BMAX = '1;
  localparam logic [SW-1:0] SMAX = SW'(LOG2N - 1);

  // Handshake: a bundle transfers on a rising edge where out_valid && out_ready;
  // once out_valid is high the bundle holds stable until that transfer.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t        state_q, state_nxt;
  logic [SW-1:0] s_q, s_nxt;
  logic [BW-1:0] b_q, b_nxt;
  logic          load;

  logic [LOG2N-1:0] bx, one_s, pos, grp, top_nxt, bot_nxt, kx;
  logic [3:0]       k16;
  logic [7:0]       tw_nxt;
  logic             last_nxt;

  // Twiddles quantised on a 16-point grid; smaller N index it with a stride.
  function automatic logic [7:0] tw_rom(input logic [3:0] k);
    logic [7:0] v;
    case (k)
      4'd0:    v = {4'b0010, 4'b0000};
      4'd1:    v = {4'b0010, 4'b1001};
      4'd2:    v = {4'b0001, 4'b1001};
      4'd3:    v = {4'b0001, 4'b1010};
      4'd4:    v = {4'b0000, 4'b1010};
      4'd5:    v = {4'b1001, 4'b1010};
      4'd6:    v = {4'b1001, 4'b1001};
      4'd7:    v = {4'b1010, 4'b1001};
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  always_comb begin
    state_nxt = state_q;
    s_nxt     = s_q;
    b_nxt     = b_q;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          s_nxt     = '0;
          b_nxt     = '0;
          load      = 1'b1;
        end
      end
      RUN: begin
        if (out_ready) begin
          if (last) begin
            state_nxt = DONE;
          end else begin
            load = 1'b1;
            if (b_q == BMAX) begin
              b_nxt = '0;
              s_nxt = s_q + SW'(1);
            end else begin
              b_nxt = b_q + BW'(1);
            end
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Payload for the bundle about to be loaded, computed from the next (s,b).
  always_comb begin
    bx       = LOG2N'(b_nxt);
    one_s    = LOG2N'(1) << s_nxt;
    pos      = bx & (one_s - LOG2N'(1));
    grp      = bx >> s_nxt;
    top_nxt  = ((grp << s_nxt) << 1) + pos;
    bot_nxt  = top_nxt + one_s;
    kx       = pos << (SMAX - s_nxt);
    k16      = 4'(kx) << (4 - LOG2N);
    tw_nxt   = tw_rom(k16);
    last_nxt = (s_nxt == SMAX) && (b_nxt == BMAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      s_q       <= '0;
      b_q       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      tw_re     <= '0;
      tw_im     <= '0;
      addr_top  <= '0;
      addr_bot  <= '0;
      last      <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      s_q       <= s_nxt;
      b_q       <= b_nxt;
      out_valid <= (state_nxt == RUN);
      busy      <= (state_nxt == RUN);
      done      <= (state_nxt == DONE);
      if (load) begin
        tw_re    <= tw_nxt[7:4];
        tw_im    <= tw_nxt[3:0];
        addr_top <= top_nxt;
        addr_bot <= bot_nxt;
        last     <= last_nxt;
      end
    end
  end

  assign stage     = s_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_fp4_twiddle_seq.sv
// Directed bench for fp4_twiddle_seq at N=8: reset, full sweep, backpressure,
// ignored start during RUN and asynchronous reset mid-transform.
module tb_fp4_twiddle_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [3:0] tw_re, tw_im;
  logic [2:0] addr_top, addr_bot;
  logic [1:0] stage;
  logic       last, busy, done;
  logic [1:0] state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  // Hand-computed bundle sequence for N=8: stage, top, bot, k
  int e_stage [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
  int e_top   [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int e_bot   [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int e_k     [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
  int e_re    [4]  = '{4'b0010, 4'b0001, 4'b0000, 4'b1001};
  int e_im    [4]  = '{4'b0000, 4'b1001, 4'b1010, 4'b1001};
  logic [15:0] exp_q[$];

  fp4_twiddle_seq #(.LOG2N(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .out_ready(out_ready),
    .out_valid(out_valid), .tw_re(tw_re), .tw_im(tw_im),
    .addr_top(addr_top), .addr_bot(addr_bot), .stage(stage),
    .last(last), .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_re"}, tw_re, 0);
    check({tag, "_im"}, tw_im, 0);
    check({tag, "_top"}, addr_top, 0);
    check({tag, "_bot"}, addr_bot, 0);
    check({tag, "_stage"}, stage, 0);
    check({tag, "_last"}, last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_state"}, state_dbg, 0);
  endtask

  function automatic void load_expected();
    exp_q.delete();
    for (int i = 0; i < 12; i++)
      exp_q.push_back({2'(e_stage[i]), 3'(e_top[i]), 3'(e_bot[i]),
                       4'(e_re[e_k[i]]), 4'(e_im[e_k[i]])});
  endfunction

  // Runs one transform; stall_idx freezes that bundle for 3 cycles, start_idx
  // pulses start while that bundle is presented, reset_idx aborts with rst_n.
  task automatic run_xfer(input int stall_idx, input int start_idx, input int reset_idx);
    int idx = 0;
    int stalls = 0;
    int guard = 0;
    logic [15:0] e;
    load_expected();
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (idx < 12 && guard < 100) begin
      guard++;
      e = exp_q[idx];
      if (idx == reset_idx) begin
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_idle", out_valid, 0);
        return;
      end
      check("valid", out_valid, 1);
      check("busy", busy, 1);
      check("state_run", state_dbg, 1);
      check("stage", stage, e[15:14]);
      check("top", addr_top, e[13:11]);
      check("bot", addr_bot, e[10:8]);
      check("tw_re", tw_re, e[7:4]);
      check("tw_im", tw_im, e[3:0]);
      check("last", last, (idx == 11));
      if (idx == stall_idx && stalls < 3) begin
        out_ready = 1'b0;
        stalls++;
      end else begin
        out_ready = 1'b1;
        idx++;
      end
      start = (idx == start_idx) && (out_ready == 1'b1);
      @(negedge clk);
    end
    start = 1'b0;
    out_ready = 1'b1;
    check("accepted_count", idx, 12);
    check("done_pulse", done, 1);
    check("done_valid", out_valid, 0);
    check("done_busy", busy, 0);
    check("state_done", state_dbg, 2);
    @(negedge clk);
    check("done_clear", done, 0);
    check("state_idle", state_dbg, 0);
    repeat (3) @(negedge clk);
    check("no_restart", out_valid, 0);
    check("no_extra_done", done, 0);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      start = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    check_zero("reset");
    start = 1'b0;
    out_ready = 1'b1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_no_start", out_valid, 0);
    check("idle_busy", busy, 0);

    run_xfer(-1, -1, -1);
    run_xfer(1, -1, -1);
    run_xfer(-1, 5, -1);
    run_xfer(-1, -1, 6);
    run_xfer(-1, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
